// File: rtl/spi_word_receiver.sv
// SPI slave word receiver: synchronizes sck/sdi/cs into clk, assembles WIDTH-bit
// words and queues them in a small first-word-fall-through FIFO.
module spi_word_receiver #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MODE      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sck,
    input  logic                       sdi,
    input  logic                       cs,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       frame_abort,
    input  logic                       clr_flags
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);
    localparam bit SAMPLE_RISE = (MODE == 0) || (MODE == 3);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic sck_s1_q, sck_s2_q, sck_prev_q;
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic sdi_s1_q, sdi_s2_q;

    state_t state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_in;
    logic             frame_abort_q, frame_abort_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] fifo_mem [DEPTH];

    logic sck_edge, cs_rise, cs_fall, sample_en, sample_fire;
    logic push, pop, full, do_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            cs_s1_q    <= 1'b0;
            cs_s2_q    <= 1'b0;
            cs_prev_q  <= 1'b0;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
        end else begin
            sck_s1_q   <= sck;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            cs_s1_q    <= cs;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            sdi_s1_q   <= sdi;
            sdi_s2_q   <= sdi_s1_q;
        end
    end

    assign sck_edge = SAMPLE_RISE ? (sck_s2_q & ~sck_prev_q) : (~sck_s2_q & sck_prev_q);
    assign cs_rise  = cs_s2_q & ~cs_prev_q;
    assign cs_fall  = ~cs_s2_q & cs_prev_q;

    // Receive FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Receive FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_rise) state_d = ACTIVE;
            ACTIVE:  if (cs_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Receive FSM: outputs. Gating on ACTIVE means a reset mid-frame waits for a new cs rise.
    always_comb begin
        sample_en     = (state_q == ACTIVE) && cs_s2_q;
        frame_abort_d = (state_q == ACTIVE) && cs_fall && (bit_cnt_q != '0);
    end

    assign sample_fire = sample_en & sck_edge;

    always_comb begin
        if (MSB_FIRST != 0) shift_in = {shift_q[WIDTH-2:0], sdi_s2_q};
        else                shift_in = {sdi_s2_q, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        if (cs_rise || cs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (sample_fire) begin
            shift_d = shift_in;
            if (bit_cnt_q == CNT_MAX) begin
                bit_cnt_d = '0;
                push      = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    assign full    = (level_q == LEVEL_MAX);
    assign pop     = out_valid & out_ready;
    assign do_push = push & (~full | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !do_push) level_d = level_q - LW'(1);
        if (clr_flags) overflow_d = 1'b0;
        // A drop in the same cycle as a clear wins, so no overflow is ever lost.
        if (push && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            frame_abort_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            frame_abort_q <= frame_abort_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= shift_in;
    end

    assign out_data    = fifo_mem[rd_ptr_q];
    assign out_valid   = (level_q != '0);
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: doc/spi_word_receiver.md
SPI_WORD_RECEIVER -- requirements
Module: spi_word_receiver

Interface
REQ-001 Parameter WIDTH, default 8, bits per SPI word (2..32).
REQ-002 Parameter DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-003 Parameter MODE, default 0, SPI mode 0..3 (bit1 = CPOL, bit0 = CPHA).
REQ-004 Parameter MSB_FIRST, default 1; 1 = first received bit lands in data[WIDTH-1], 0 = first bit lands in data[0].
REQ-005 clk  in  1  system clock; all state clocked on posedge clk.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 sck  in  1  SPI clock from the MCU, asynchronous to clk.
REQ-008 sdi  in  1  SPI serial data from the MCU, asynchronous to clk.
REQ-009 cs  in  1  frame select, active-high (1 = transfer in progress), asynchronous to clk.
REQ-010 out_data  out  WIDTH  FIFO head word.
REQ-011 out_valid  out  1  FIFO non-empty.
REQ-012 out_ready  in  1  consumer accepts the head word.
REQ-013 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
REQ-015 frame_abort  out  1  one-cycle pulse; cs fell with a partial word pending.
REQ-016 clr_flags  in  1  synchronous clear of overflow.

Function
REQ-017 sck, sdi and cs SHALL each pass through a two-flop synchronizer to clk before any use.
REQ-018 Sample edge, on synchronized sck: rising for MODE 0 and 3; falling for MODE 1 and 2.
REQ-019 Sample edge detected while synchronized cs = 1: shift synchronized sdi into the shift register (direction per MSB_FIRST); increment the bit counter.
REQ-020 Bit counter: 0..WIDTH-1; on the WIDTH-th sample it wraps to 0, and the assembled word, including the bit sampled at that edge, is pushed to the FIFO at that same clk edge.
REQ-021 Rising edge of synchronized cs clears the bit counter and the shift register.
REQ-022 Falling edge of synchronized cs with bit counter != 0: discard the partial word, clear the counter, pulse frame_abort for exactly one cycle. With counter = 0: no pulse.
REQ-023 Sample edges while synchronized cs = 0 SHALL be ignored.
REQ-024 Receive FSM states: IDLE (cs=0), ACTIVE (cs=1). Transitions:
  - IDLE->ACTIVE on cs rise.
  - ACTIVE->IDLE on cs fall.
  - Multiple words per frame are legal; the counter wraps per REQ-020.
REQ-025 Latency: out_valid SHALL rise on the clk edge after the push edge when the FIFO was empty; worst case sdi-to-out_valid = 4 clk cycles after the sampling sck edge.
REQ-026 FIFO: first-word fall-through; out_data = oldest entry whenever out_valid = 1; out_data undefined-but-stable when empty.
REQ-027 Pop occurs when out_valid & out_ready at a clk edge.
REQ-028 Push while full without simultaneous pop: drop the new word, set overflow, leave FIFO contents and level unchanged.
REQ-029 Push and pop in the same cycle when full: both occur, level unchanged, overflow not set.
REQ-030 out_ready while empty: no effect; level never underflows.
REQ-031 Read and write pointers wrap modulo DEPTH; level SHALL equal pushes minus pops, range 0..DEPTH.
REQ-032 clr_flags = 1 clears overflow next edge; a simultaneous overflow event takes priority (overflow stays 1).
REQ-033 sck frequency SHALL be <= clk/4; behaviour above this is unspecified.

Reset
REQ-034 reset = 1 SHALL immediately (asynchronously) force all of the following to 0, and synchronizer flops to 0:
  - out_valid, level, overflow, frame_abort;
  - bit counter, shift register;
  - FIFO pointers;
  - FSM to IDLE.
REQ-035 Reset mid-frame: the partial word is discarded. After release, sampling resumes only after a fresh cs rise is seen.

Verification
REQ-036 WIDTH=8, MODE 0: cs high, shift 0xA5 MSB-first, cs low -> out_valid within 4 clk of the 8th sck rise, out_data=0xA5, level=1, frame_abort stays 0.
REQ-037 MODE 3, MSB_FIRST=0: shift bits 1,0,0,0,0,0,0,0 -> out_data=0x01.
REQ-038 DEPTH=4, out_ready=0: send 5 words 0x11..0x55 -> level=4, overflow=1; drain gives 0x11,0x22,0x33,0x44; clr_flags -> overflow=0.
REQ-039 cs falls after 3 bits -> single-cycle frame_abort, no push. Next full frame 0x3C is received correctly.
REQ-040 FIFO full, out_ready=1 held while a 5th word completes -> pop and push in the same cycle, level stays 4, overflow=0.
REQ-041 Assert reset after 5 bits of a frame with 2 words queued -> out_valid=0, level=0 immediately. After release, a new cs frame of 0x7E yields exactly one word, 0x7E.
